// File: rtl/demux1t8_frame_pkg.sv
// demux1t8_frame_pkg: shared channel count, index width and FSM encoding for the 1-to-8 frame demux
package demux1t8_frame_pkg;
  localparam int N_CH = 8;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, COMMIT = 2'd2} st_t;
endpackage

// File: rtl/demux1t8_frame_shadow_bank.sv
// demux_shadow_bank: 8 x DATA_W shadow registers; ports clk, rst_n, clr (sync clear), we/idx/din write port, q (all entries flat, entry i at q[i*DATA_W +: DATA_W])
module demux_shadow_bank
  import demux1t8_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     we,
  input  logic [IDX_W-1:0]         idx,
  input  logic [DATA_W-1:0]        din,
  output logic [N_CH*DATA_W-1:0]   q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (we) q[idx*DATA_W +: DATA_W] <= din;
endmodule

// File: rtl/demux1t8_frame.sv
// demux1t8_frame: byte stream to 8 double-buffered channels; ports clk, rst_n, s_valid/s_ready/s_data/s_last in, clr, o0..o7 committed channels, wr_ptr, frame_done, short_frame, frame_cnt
module demux1t8_frame
  import demux1t8_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              clr,
  output logic [DATA_W-1:0] o0,
  output logic [DATA_W-1:0] o1,
  output logic [DATA_W-1:0] o2,
  output logic [DATA_W-1:0] o3,
  output logic [DATA_W-1:0] o4,
  output logic [DATA_W-1:0] o5,
  output logic [DATA_W-1:0] o6,
  output logic [DATA_W-1:0] o7,
  output logic [IDX_W-1:0]  wr_ptr,
  output logic              frame_done,
  output logic              short_frame,
  output logic [7:0]        frame_cnt
);
  st_t st;
  logic short_q;
  logic accept;
  logic end_frame;
  logic [N_CH*DATA_W-1:0] sh;
  logic [DATA_W-1:0] o [N_CH];
  assign s_ready = rst_n & (st != COMMIT) & ~clr;
  assign accept = s_valid & s_ready;
  assign end_frame = accept & (s_last | (&wr_ptr));
  demux_shadow_bank #(.DATA_W(DATA_W)) u_bank (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .we   (accept),
    .idx  (wr_ptr),
    .din  (s_data),
    .q    (sh)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      wr_ptr <= '0;
      short_q <= 1'b0;
      frame_done <= 1'b0;
      short_frame <= 1'b0;
      frame_cnt <= '0;
      for (int i = 0; i < N_CH; i++) o[i] <= '0;
    end else if (clr) begin
      st <= IDLE;
      wr_ptr <= '0;
      frame_done <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      st <= st == COMMIT ? IDLE : end_frame ? COMMIT : accept ? FILL : st;
      wr_ptr <= end_frame ? '0 : wr_ptr + {{(IDX_W-1){1'b0}}, accept};
      short_q <= end_frame ? (s_last & ~(&wr_ptr)) : short_q;
      frame_done <= st == COMMIT;
      short_frame <= (st == COMMIT) & short_q;
      if (st == COMMIT) begin
        frame_cnt <= frame_cnt + 8'd1;
        for (int i = 0; i < N_CH; i++) o[i] <= sh[i*DATA_W +: DATA_W];
      end
    end
  assign o0 = o[0];
  assign o1 = o[1];
  assign o2 = o[2];
  assign o3 = o[3];
  assign o4 = o[4];
  assign o5 = o[5];
  assign o6 = o[6];
  assign o7 = o[7];
endmodule

// File: tb/tb_demux1t8_frame.sv
// tb_demux1t8_frame: randomized frame-level reference-model bench for demux1t8_frame
module tb_demux1t8_frame;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic clr = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_ready, frame_done, short_frame;
  logic [2:0] wr_ptr;
  logic [7:0] frame_cnt;
  logic [7:0] o [8];
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [7:0] sh_m [8];
  logic [7:0] out_m [8];
  int idx_m;
  int cnt_m;
  demux1t8_frame #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .clr        (clr),
    .o0         (o[0]),
    .o1         (o[1]),
    .o2         (o[2]),
    .o3         (o[3]),
    .o4         (o[4]),
    .o5         (o[5]),
    .o6         (o[6]),
    .o7         (o[7]),
    .wr_ptr     (wr_ptr),
    .frame_done (frame_done),
    .short_frame(short_frame),
    .frame_cnt  (frame_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done) pulses++;
  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_outs(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_o%0d", tag, i), 32'(o[i]), 32'(out_m[i]));
  endtask
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      sh_m[i] = 8'h00;
      out_m[i] = 8'h00;
    end
    idx_m = 0;
    cnt_m = 0;
  endtask
  task automatic put(input logic [7:0] d, input bit last, input int gaps, input bit cancel);
    int n;
    bit rdy, done, shrt;
    for (int g = 0; g < gaps; g++) begin
      s_valid = 1'b0;
      s_data = 8'($urandom);
      s_last = 1'($urandom);
      @(negedge clk);
    end
    if (gaps > 0) check("idle_ptr", 32'(wr_ptr), 32'(idx_m));
    s_valid = 1'b1;
    s_data = d;
    s_last = last;
    n = 0;
    #1 rdy = s_ready;
    while (!rdy && n < 16) begin
      @(negedge clk);
      #1 rdy = s_ready;
      n++;
    end
    if (!rdy) begin
      check("ready_timeout", 32'(rdy), 32'(1));
      s_valid = 1'b0;
      s_last = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    sh_m[idx_m] = d;
    done = last || idx_m == 7;
    shrt = last && idx_m != 7;
    idx_m = done ? 0 : idx_m + 1;
    check("wr_ptr", 32'(wr_ptr), 32'(idx_m));
    if (done) begin
      check("commit_ready", 32'(s_ready), 32'(0));
      check("early_done", 32'(frame_done), 32'(0));
      if (cancel) begin
        @(negedge clk);
        clr = 1'b1;
        s_valid = 1'b0;
        for (int i = 0; i < 8; i++) sh_m[i] = 8'h00;
        @(posedge clk);
        #1;
        check("cancel_done", 32'(frame_done), 32'(0));
      end else begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) out_m[i] = sh_m[i];
        cnt_m = (cnt_m + 1) % 256;
        check("frame_done", 32'(frame_done), 32'(1));
        check("short_frame", 32'(short_frame), 32'(shrt));
      end
      check_outs("commit");
      check("frame_cnt", 32'(frame_cnt), 32'(cnt_m));
      check("post_ptr", 32'(wr_ptr), 32'(0));
    end
    @(negedge clk);
    clr = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask
  task automatic rand_frame(input int n, input int gapmax);
    for (int i = 0; i < n; i++) put(8'($urandom), i == n - 1 && n < 8, $urandom_range(0, gapmax), 1'b0);
  endtask
  initial begin
    int p0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs("reset");
    check("reset_cnt", 32'(frame_cnt), 32'(0));
    check("reset_ptr", 32'(wr_ptr), 32'(0));
    check("reset_done", 32'(frame_done), 32'(0));
    check("reset_short", 32'(short_frame), 32'(0));
    check("reset_ready", 32'(s_ready), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(s_ready), 32'(1));
    for (int i = 0; i < 8; i++) put(8'(8'h11 * (i + 1)), 1'b0, 0, 1'b0);
    put(8'hA0, 1'b0, 0, 1'b0);
    put(8'hA1, 1'b1, 0, 1'b0);
    for (int i = 0; i < 8; i++) put(8'(8'h11 * (i + 1)), i == 7, $urandom_range(0, 3), 1'b0);
    for (int i = 0; i < 3; i++) put(8'($urandom), 1'b0, $urandom_range(0, 2), 1'b0);
    s_valid = 1'b1;
    s_data = 8'hFF;
    clr = 1'b1;
    #1 check("clr_ready", 32'(s_ready), 32'(0));
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) sh_m[i] = 8'h00;
    idx_m = 0;
    check("clr_ptr", 32'(wr_ptr), 32'(0));
    check("clr_done", 32'(frame_done), 32'(0));
    check_outs("clr");
    @(negedge clk);
    clr = 1'b0;
    s_valid = 1'b0;
    rand_frame(8, 2);
    rand_frame(2, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 8; i++) sh_m[i] = 8'h00;
    idx_m = 0;
    rand_frame(1, 0);
    for (int i = 0; i < 8; i++) put(8'($urandom), 1'b0, 0, i == 7);
    rand_frame(3, 1);
    for (int i = 0; i < 5; i++) put(8'($urandom), 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("async_rst");
    check("async_rst_cnt", 32'(frame_cnt), 32'(0));
    check("async_rst_ptr", 32'(wr_ptr), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_frame(8, 2);
    rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    p0 = pulses;
    for (int f = 0; f < 256; f++) rand_frame(8, 0);
    @(negedge clk);
    #1;
    check("wrap_cnt", 32'(frame_cnt), 32'(0));
    check("wrap_pulses", 32'(pulses - p0), 32'(256));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
